// File: rtl/tournament_pkg.sv
// Shared types, widths and counter helpers for the tournament predictor update path.
package tournament_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned GHR_W      = 12;
  localparam int unsigned LHIST_W    = 10;
  localparam int unsigned LHT_IDX_W  = 10;
  localparam int unsigned FIFO_DEPTH = 8;

  // Sweep covers the largest of the four tables.
  localparam int unsigned SWEEP_W =
    (GHR_W > LHIST_W) ? ((GHR_W > LHT_IDX_W) ? GHR_W : LHT_IDX_W)
                      : ((LHIST_W > LHT_IDX_W) ? LHIST_W : LHT_IDX_W);

  typedef logic [1:0] ctr2_t;
  localparam ctr2_t CTR_WEAK_T = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } upd_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [GHR_W-1:0]   ghr;
    logic [LHIST_W-1:0] lhist;
    logic               pred_global;
    logic               pred_local;
    logic               pred_taken;
  } branch_meta_t;

  function automatic ctr2_t sat_inc(input ctr2_t c);
    return (c == 2'b11) ? c : ctr2_t'(c + 2'b01);
  endfunction

  function automatic ctr2_t sat_dec(input ctr2_t c);
    return (c == 2'b00) ? c : ctr2_t'(c - 2'b01);
  endfunction

  function automatic ctr2_t ctr_update(input ctr2_t c, input logic up);
    return up ? sat_inc(c) : sat_dec(c);
  endfunction

endpackage

// File: rtl/branch_meta_fifo.sv
// In-order FIFO of predict-time branch metadata awaiting resolution.
module branch_meta_fifo
  import tournament_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push_valid,
  output logic         push_ready_c,
  input  branch_meta_t push_data,
  output logic         pop_valid_c,
  input  logic         pop_ready,
  output branch_meta_t pop_data_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  branch_meta_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ready_c = (count < CNT_W'(DEPTH));
  assign pop_valid_c  = (count != '0);
  assign pop_data_c   = mem[rd_ptr];
  assign push         = push_valid & push_ready_c;
  assign pop          = pop_ready & pop_valid_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only observed once pushed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tournament_update_unit.sv
// Resolution-side trainer for the tournament predictor: table init sweep,
// counter/LHT read-modify-write, mispredict flag and GHR restore.
module tournament_update_unit
  import tournament_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pred_valid,
  output logic                 pred_ready,
  input  logic [PC_W-1:0]      pred_pc,
  input  logic [GHR_W-1:0]     pred_ghr,
  input  logic [LHIST_W-1:0]   pred_lhist,
  input  logic                 pred_global,
  input  logic                 pred_local,
  input  logic                 pred_taken,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic                 res_taken,
  input  logic                 flush,
  output logic                 mispredict,
  output logic [GHR_W-1:0]     restore_ghr,
  output logic [GHR_W-1:0]     glob_rd_idx,
  output logic [LHIST_W-1:0]   loc_rd_idx,
  output logic [GHR_W-1:0]     cho_rd_idx,
  input  ctr2_t                glob_rd_data,
  input  ctr2_t                loc_rd_data,
  input  ctr2_t                cho_rd_data,
  output logic                 glob_wr_en,
  output logic [GHR_W-1:0]     glob_wr_idx,
  output ctr2_t                glob_wr_data,
  output logic                 loc_wr_en,
  output logic [LHIST_W-1:0]   loc_wr_idx,
  output ctr2_t                loc_wr_data,
  output logic                 cho_wr_en,
  output logic [GHR_W-1:0]     cho_wr_idx,
  output ctr2_t                cho_wr_data,
  output logic                 lht_wr_en,
  output logic [LHT_IDX_W-1:0] lht_wr_idx,
  output logic [LHIST_W-1:0]   lht_wr_data,
  output logic                 init_done
);

  localparam int unsigned SWEEP_CW   = SWEEP_W + 1;
  localparam int unsigned SWEEP_SIZE = 2 ** SWEEP_W;

  upd_state_t          state;
  upd_state_t          state_nxt;
  logic [SWEEP_CW-1:0] sweep_cnt;
  logic                sweep_en;
  logic [SWEEP_W-1:0]  sweep_idx;
  logic                sweep_more;

  branch_meta_t        push_meta;
  branch_meta_t        head;
  logic                head_valid;
  logic                fifo_push_ready;
  logic                run;
  logic                res_fire;

  logic                s1_valid;
  branch_meta_t        s1_meta;
  logic                s1_taken;

  logic                prev_glob_en;
  logic [GHR_W-1:0]    prev_glob_idx;
  ctr2_t               prev_glob_data;
  logic                prev_loc_en;
  logic [LHIST_W-1:0]  prev_loc_idx;
  ctr2_t               prev_loc_data;
  logic                prev_cho_en;
  logic [GHR_W-1:0]    prev_cho_idx;
  ctr2_t               prev_cho_data;

  ctr2_t               glob_old;
  ctr2_t               loc_old;
  ctr2_t               cho_old;
  logic                unused_pc_bits;

  assign run        = (state == ST_RUN);
  assign init_done  = run;
  assign pred_ready = run & fifo_push_ready & ~flush;
  assign res_ready  = run & head_valid;
  assign res_fire   = res_valid & res_ready;
  assign sweep_more = (sweep_cnt < SWEEP_CW'(SWEEP_SIZE));

  assign push_meta.pc          = pred_pc;
  assign push_meta.ghr         = pred_ghr;
  assign push_meta.lhist       = pred_lhist;
  assign push_meta.pred_global = pred_global;
  assign push_meta.pred_local  = pred_local;
  assign push_meta.pred_taken  = pred_taken;

  assign unused_pc_bits = ^{s1_meta.pc[PC_W-1:LHT_IDX_W+2], s1_meta.pc[1:0]};

  branch_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .clear        (flush),
    .push_valid   (pred_valid & run & ~flush),
    .push_ready_c (fifo_push_ready),
    .push_data    (push_meta),
    .pop_valid_c  (head_valid),
    .pop_ready    (res_valid & run),
    .pop_data_c   (head)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next-state: leave INIT once every index has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_cnt == SWEEP_CW'(SWEEP_SIZE)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  // Sweep counter; write strobe is registered so nothing writes during reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sweep_cnt <= '0;
      sweep_en  <= 1'b0;
      sweep_idx <= '0;
    end else if (state == ST_INIT) begin
      sweep_en  <= sweep_more;
      sweep_idx <= sweep_cnt[SWEEP_W-1:0];
      if (sweep_more) sweep_cnt <= SWEEP_CW'(sweep_cnt + 1'b1);
    end else begin
      sweep_en  <= 1'b0;
    end
  end

  // S0 -> S1 capture of the resolved head entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_meta  <= '0;
      s1_taken <= 1'b0;
    end else begin
      s1_valid <= res_fire;
      if (res_fire) begin
        s1_meta  <= head;
        s1_taken <= res_taken;
      end
    end
  end

  // Last cycle's writes, forwarded because the tables return pre-write data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_glob_en   <= 1'b0;
      prev_glob_idx  <= '0;
      prev_glob_data <= '0;
      prev_loc_en    <= 1'b0;
      prev_loc_idx   <= '0;
      prev_loc_data  <= '0;
      prev_cho_en    <= 1'b0;
      prev_cho_idx   <= '0;
      prev_cho_data  <= '0;
    end else begin
      prev_glob_en   <= glob_wr_en;
      prev_glob_idx  <= glob_wr_idx;
      prev_glob_data <= glob_wr_data;
      prev_loc_en    <= loc_wr_en;
      prev_loc_idx   <= loc_wr_idx;
      prev_loc_data  <= loc_wr_data;
      prev_cho_en    <= cho_wr_en;
      prev_cho_idx   <= cho_wr_idx;
      prev_cho_data  <= cho_wr_data;
    end
  end

  // Outputs: table reads from the head, writes from the sweep or from S1.
  always_comb begin
    glob_rd_idx  = '0;
    loc_rd_idx   = '0;
    cho_rd_idx   = '0;
    glob_wr_en   = 1'b0;
    glob_wr_idx  = '0;
    glob_wr_data = '0;
    loc_wr_en    = 1'b0;
    loc_wr_idx   = '0;
    loc_wr_data  = '0;
    cho_wr_en    = 1'b0;
    cho_wr_idx   = '0;
    cho_wr_data  = '0;
    lht_wr_en    = 1'b0;
    lht_wr_idx   = '0;
    lht_wr_data  = '0;
    mispredict   = 1'b0;
    restore_ghr  = '0;

    glob_old = (prev_glob_en && prev_glob_idx == s1_meta.ghr)   ? prev_glob_data : glob_rd_data;
    loc_old  = (prev_loc_en  && prev_loc_idx  == s1_meta.lhist) ? prev_loc_data  : loc_rd_data;
    cho_old  = (prev_cho_en  && prev_cho_idx  == s1_meta.ghr)   ? prev_cho_data  : cho_rd_data;

    if (res_ready) begin
      glob_rd_idx = head.ghr;
      cho_rd_idx  = head.ghr;
      loc_rd_idx  = head.lhist;
    end

    if (sweep_en) begin
      glob_wr_en   = 1'b1;
      glob_wr_idx  = sweep_idx[GHR_W-1:0];
      glob_wr_data = CTR_WEAK_T;
      loc_wr_en    = 1'b1;
      loc_wr_idx   = sweep_idx[LHIST_W-1:0];
      loc_wr_data  = CTR_WEAK_T;
      cho_wr_en    = 1'b1;
      cho_wr_idx   = sweep_idx[GHR_W-1:0];
      cho_wr_data  = CTR_WEAK_T;
      lht_wr_en    = 1'b1;
      lht_wr_idx   = sweep_idx[LHT_IDX_W-1:0];
      lht_wr_data  = '0;
    end else if (s1_valid) begin
      glob_wr_en   = 1'b1;
      glob_wr_idx  = s1_meta.ghr;
      glob_wr_data = ctr_update(glob_old, s1_taken);
      loc_wr_en    = 1'b1;
      loc_wr_idx   = s1_meta.lhist;
      loc_wr_data  = ctr_update(loc_old, s1_taken);
      // Choice trains toward whichever component was right, only on disagreement.
      if (s1_meta.pred_global != s1_meta.pred_local) begin
        cho_wr_en   = 1'b1;
        cho_wr_idx  = s1_meta.ghr;
        cho_wr_data = ctr_update(cho_old, s1_meta.pred_global == s1_taken);
      end
      lht_wr_en    = 1'b1;
      lht_wr_idx   = s1_meta.pc[LHT_IDX_W+1:2];
      lht_wr_data  = {s1_meta.lhist[LHIST_W-2:0], s1_taken};
      mispredict   = (s1_meta.pred_taken != s1_taken);
      restore_ghr  = {s1_meta.ghr[GHR_W-2:0], s1_taken};
    end
  end

endmodule

// File: tb/tb_tournament_update_unit.sv
// Directed self-checking bench for tournament_update_unit.
module tb_tournament_update_unit;
  import tournament_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 pred_valid;
  logic                 pred_ready;
  logic [PC_W-1:0]      pred_pc;
  logic [GHR_W-1:0]     pred_ghr;
  logic [LHIST_W-1:0]   pred_lhist;
  logic                 pred_global;
  logic                 pred_local;
  logic                 pred_taken;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_taken;
  logic                 flush;
  logic                 mispredict;
  logic [GHR_W-1:0]     restore_ghr;
  logic [GHR_W-1:0]     glob_rd_idx;
  logic [LHIST_W-1:0]   loc_rd_idx;
  logic [GHR_W-1:0]     cho_rd_idx;
  ctr2_t                glob_rd_data;
  ctr2_t                loc_rd_data;
  ctr2_t                cho_rd_data;
  logic                 glob_wr_en;
  logic [GHR_W-1:0]     glob_wr_idx;
  ctr2_t                glob_wr_data;
  logic                 loc_wr_en;
  logic [LHIST_W-1:0]   loc_wr_idx;
  ctr2_t                loc_wr_data;
  logic                 cho_wr_en;
  logic [GHR_W-1:0]     cho_wr_idx;
  ctr2_t                cho_wr_data;
  logic                 lht_wr_en;
  logic [LHT_IDX_W-1:0] lht_wr_idx;
  logic [LHIST_W-1:0]   lht_wr_data;
  logic                 init_done;

  int checks = 0;
  int errors = 0;

  tournament_update_unit dut (
    .clock        (clock),
    .reset        (reset),
    .pred_valid   (pred_valid),
    .pred_ready   (pred_ready),
    .pred_pc      (pred_pc),
    .pred_ghr     (pred_ghr),
    .pred_lhist   (pred_lhist),
    .pred_global  (pred_global),
    .pred_local   (pred_local),
    .pred_taken   (pred_taken),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_taken    (res_taken),
    .flush        (flush),
    .mispredict   (mispredict),
    .restore_ghr  (restore_ghr),
    .glob_rd_idx  (glob_rd_idx),
    .loc_rd_idx   (loc_rd_idx),
    .cho_rd_idx   (cho_rd_idx),
    .glob_rd_data (glob_rd_data),
    .loc_rd_data  (loc_rd_data),
    .cho_rd_data  (cho_rd_data),
    .glob_wr_en   (glob_wr_en),
    .glob_wr_idx  (glob_wr_idx),
    .glob_wr_data (glob_wr_data),
    .loc_wr_en    (loc_wr_en),
    .loc_wr_idx   (loc_wr_idx),
    .loc_wr_data  (loc_wr_data),
    .cho_wr_en    (cho_wr_en),
    .cho_wr_idx   (cho_wr_idx),
    .cho_wr_data  (cho_wr_data),
    .lht_wr_en    (lht_wr_en),
    .lht_wr_idx   (lht_wr_idx),
    .lht_wr_data  (lht_wr_data),
    .init_done    (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pred(input logic [11:0] ghr, input logic [9:0] lh, input logic g,
                          input logic l, input logic t, input logic [31:0] pc);
    pred_ghr    = ghr;
    pred_lhist  = lh;
    pred_global = g;
    pred_local  = l;
    pred_taken  = t;
    pred_pc     = pc;
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    int bad;
    reset        = 1'b0;
    pred_valid   = 1'b0;
    res_valid    = 1'b0;
    res_taken    = 1'b0;
    flush        = 1'b0;
    glob_rd_data = 2'b10;
    loc_rd_data  = 2'b10;
    cho_rd_data  = 2'b10;
    set_pred(12'h0, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset: every output low.
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({glob_wr_en, loc_wr_en, cho_wr_en, lht_wr_en, init_done,
                              pred_ready, res_ready, mispredict}), 32'h0);
    chk("reset_restore", 32'(restore_ghr), 32'h0);

    // Init sweep: 4096 consecutive writes with ascending indices.
    reset = 1'b1;
    seen  = 0;
    bad   = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clock);
      if (glob_wr_en) begin
        if (!(loc_wr_en && cho_wr_en && lht_wr_en) ||
            glob_wr_idx != 12'(seen) || cho_wr_idx != 12'(seen) ||
            loc_wr_idx != 10'(seen) || lht_wr_idx != 10'(seen) ||
            glob_wr_data != 2'b10 || loc_wr_data != 2'b10 || cho_wr_data != 2'b10 ||
            lht_wr_data != 10'h0 || pred_ready || init_done)
          bad++;
        seen++;
      end else if (seen > 0) begin
        break;
      end
    end
    chk("sweep_length", 32'(seen), 32'd4096);
    chk("sweep_content", 32'(bad), 32'd0);
    chk("init_done", 32'(init_done), 32'h1);
    chk("pred_ready_after_init", 32'(pred_ready), 32'h1);
    chk("res_ready_empty", 32'(res_ready), 32'h0);

    // Single mispredicted branch.
    set_pred(12'h0A5, 10'h000, 1'b1, 1'b0, 1'b1, 32'h0000_0104);
    pred_valid = 1'b1;
    cycle();
    pred_valid = 1'b0;
    #1;
    chk("s0_res_ready", 32'(res_ready), 32'h1);
    chk("s0_glob_rd_idx", 32'(glob_rd_idx), 32'h0A5);
    chk("s0_cho_rd_idx", 32'(cho_rd_idx), 32'h0A5);
    chk("s0_loc_rd_idx", 32'(loc_rd_idx), 32'h000);
    res_valid = 1'b1;
    res_taken = 1'b0;
    cycle();
    res_valid = 1'b0;
    #1;
    chk("mp_mispredict", 32'(mispredict), 32'h1);
    chk("mp_restore_ghr", 32'(restore_ghr), 32'h14A);
    chk("mp_glob_wr", 32'({glob_wr_en, glob_wr_idx, glob_wr_data}), 32'({1'b1, 12'h0A5, 2'b01}));
    chk("mp_cho_wr", 32'({cho_wr_en, cho_wr_idx, cho_wr_data}), 32'({1'b1, 12'h0A5, 2'b01}));
    chk("mp_loc_wr", 32'({loc_wr_en, loc_wr_idx, loc_wr_data}), 32'({1'b1, 10'h000, 2'b01}));
    chk("mp_lht_wr", 32'({lht_wr_en, lht_wr_idx, lht_wr_data}), 32'({1'b1, 10'h041, 10'h000}));
    cycle();
    #1;
    chk("mp_pulse_end", 32'({mispredict, glob_wr_en}), 32'h0);

    // Back-to-back same-index updates, taken then not-taken.
    for (int pass = 0; pass < 2; pass++) begin
      set_pred(12'h123, 10'h155, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      pred_valid = 1'b1;
      cycle();
      cycle();
      pred_valid = 1'b0;
      res_valid  = 1'b1;
      res_taken  = (pass == 0);
      cycle();
      #1;
      chk("b2b_first_glob", 32'(glob_wr_data), (pass == 0) ? 32'h3 : 32'h1);
      chk("b2b_first_loc", 32'(loc_wr_data), (pass == 0) ? 32'h3 : 32'h1);
      chk("b2b_no_cho", 32'(cho_wr_en), 32'h0);
      cycle();
      res_valid = 1'b0;
      #1;
      chk("b2b_second_glob", 32'({glob_wr_en, glob_wr_data}), (pass == 0) ? 32'h7 : 32'h4);
      chk("b2b_second_loc", 32'({loc_wr_en, loc_wr_data}), (pass == 0) ? 32'h7 : 32'h4);
      cycle();
    end

    // Fill FIFO, then dequeue with enqueue held.
    for (int i = 0; i < 8; i++) begin
      set_pred(12'(12'h100 + i), 10'h0, 1'b1, 1'b1, 1'b1, 32'h0);
      pred_valid = 1'b1;
      cycle();
    end
    set_pred(12'h077, 10'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    #1;
    chk("full_ready", 32'(pred_ready), 32'h0);
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    chk("full_deq_ready", 32'(pred_ready), 32'h0);
    cycle();
    res_valid = 1'b0;
    #1;
    chk("ready_after_deq", 32'(pred_ready), 32'h1);
    cycle();
    pred_valid = 1'b0;
    #1;
    chk("refull_ready", 32'(pred_ready), 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk("fifo_order", 32'(glob_rd_idx), (k < 7) ? 32'(32'h101 + k) : 32'h077);
      res_valid = 1'b1;
      cycle();
    end
    res_valid = 1'b0;
    #1;
    chk("drained_res_ready", 32'(res_ready), 32'h0);
    cycle();

    // Flush concurrent with a resolution and an enqueue.
    for (int i = 0; i < 3; i++) begin
      set_pred(12'(12'h200 + i), 10'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      pred_valid = 1'b1;
      cycle();
    end
    set_pred(12'h2FF, 10'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    flush     = 1'b1;
    res_valid = 1'b1;
    res_taken = 1'b1;
    #1;
    chk("flush_pred_ready", 32'(pred_ready), 32'h0);
    chk("flush_res_ready", 32'(res_ready), 32'h1);
    cycle();
    flush      = 1'b0;
    res_valid  = 1'b0;
    pred_valid = 1'b0;
    #1;
    chk("flush_s1_write", 32'({glob_wr_en, glob_wr_idx, glob_wr_data}), 32'({1'b1, 12'h200, 2'b11}));
    chk("flush_s1_mispredict", 32'(mispredict), 32'h1);
    chk("flush_empty", 32'(res_ready), 32'h0);
    cycle();
    #1;
    chk("flush_after", 32'({glob_wr_en, res_ready, pred_ready}), 32'h1);

    // Reset while S1 is live.
    set_pred(12'h3C3, 10'h2AA, 1'b0, 1'b1, 1'b0, 32'h0000_0ABC);
    pred_valid = 1'b1;
    cycle();
    pred_valid = 1'b0;
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    cycle();
    res_valid = 1'b0;
    #1;
    chk("pre_reset_glob", 32'({glob_wr_en, glob_wr_idx, glob_wr_data}), 32'({1'b1, 12'h3C3, 2'b11}));
    chk("pre_reset_cho", 32'({cho_wr_en, cho_wr_data}), 32'h5);
    chk("pre_reset_lht", 32'({lht_wr_en, lht_wr_idx, lht_wr_data}), 32'({1'b1, 10'h2AF, 10'h155}));
    chk("pre_reset_mispredict", 32'(mispredict), 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({glob_wr_en, loc_wr_en, cho_wr_en, lht_wr_en, mispredict,
                                  init_done, res_ready, pred_ready}), 32'h0);
    cycle();
    chk("mid_reset_held", 32'({glob_wr_en, lht_wr_en, mispredict}), 32'h0);
    reset = 1'b1;
    cycle();
    chk("resweep_first", 32'({glob_wr_en, glob_wr_idx, loc_wr_idx}), 32'({1'b1, 12'h000, 10'h000}));
    cycle();
    chk("resweep_second", 32'({glob_wr_en, glob_wr_idx}), 32'({1'b1, 12'h001}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tournament_update_unit.md
Name: tournament_update_unit

Overview:
- Resolution side of the tournament branch predictor. Predict-time metadata is enqueued per branch and held in order in a FIFO until the branch resolves.
- On resolution, the unit trains the global, local and choice counter tables and the local history table (LHT) using read-modify-write.
- It flags mispredicts and supplies the corrected global history for GHR restore.
- After reset it owns table initialisation via a sweep FSM.

Parameters:
- PC_W, 32, PC width
- GHR_W, 12, global history width; global and choice tables have 2^GHR_W entries
- LHIST_W, 10, local history width; local counter table has 2^LHIST_W entries
- LHT_IDX_W, 10, LHT index width; index = pc[LHT_IDX_W+1:2]
- DEPTH, 8, in-flight branch FIFO entries (power of two)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- pred_valid  in  1  enqueue request
- pred_ready  out  1  enqueue accepted when valid&ready
- pred_pc  in  PC_W  branch PC
- pred_ghr  in  GHR_W  GHR used at predict
- pred_lhist  in  LHIST_W  local history used at predict
- pred_global  in  1  global component prediction
- pred_local  in  1  local component prediction
- pred_taken  in  1  final prediction
- res_valid  in  1  oldest branch resolved
- res_ready  out  1  resolution accepted when valid&ready
- res_taken  in  1  actual outcome
- flush  in  1  squash all queued branches
- mispredict  out  1  one-cycle pulse
- restore_ghr  out  GHR_W  corrected history, valid with mispredict
- glob_rd_idx / loc_rd_idx / cho_rd_idx  out  GHR_W/LHIST_W/GHR_W  table read index
- glob_rd_data / loc_rd_data / cho_rd_data  in  2 each  read data, returned one cycle after index
- glob_wr_en, glob_wr_idx, glob_wr_data  out  1/GHR_W/2  global table write
- loc_wr_en, loc_wr_idx, loc_wr_data  out  1/LHIST_W/2  local table write
- cho_wr_en, cho_wr_idx, cho_wr_data  out  1/GHR_W/2  choice table write
- lht_wr_en, lht_wr_idx, lht_wr_data  out  1/LHT_IDX_W/LHIST_W  LHT write
- init_done  out  1  high once the sweep completes

Behaviour:
- FSM states: INIT, RUN. Reset enters INIT with FIFO empty and sweep counter 0.
- During reset, all outputs are 0.
- INIT, each cycle:
  - Write all four tables at index = counter mod table size.
  - Counter tables get 2'b10; LHT gets 0.
  - Duration is 2^max(GHR_W,LHIST_W,LHT_IDX_W) cycles (4096 at defaults). Then go to RUN and set init_done=1.
- pred_ready = RUN & count<DEPTH & !flush. A full FIFO takes no enqueue even if a dequeue occurs in the same cycle.
- res_ready = RUN & count>0.
- S0 (accept cycle):
  - Pop the head.
  - Drive glob_rd_idx=ghr, cho_rd_idx=ghr, loc_rd_idx=lhist combinationally from the head.
  - Register the entry and res_taken into S1.
- S1 (next cycle):
  - Counters are 2-bit saturating, MSB = taken. Increment if taken, decrement otherwise; saturate at 3 and 0.
  - Always write glob and loc.
  - Write cho only if pred_global != pred_local: increment (toward global) when global was correct, else decrement.
  - lht_wr_data = {lhist[LHIST_W-2:0], res_taken}.
  - mispredict = (pred_taken != res_taken).
  - restore_ghr = {ghr[GHR_W-2:0], res_taken}.
- Tables read old data on a same-cycle read/write collision. S1 therefore forwards its own previous-cycle write data per table when the index matches and that write was enabled.
- flush:
  - Empties the FIFO next edge.
  - A resolution accepted in the same cycle completes normally.
  - An enqueue in the same cycle is dropped (pred_ready=0).
  - An update already in S1 is not cancelled.
- Reset mid-operation: S1 is discarded and the FIFO cleared. The FSM returns to INIT and the sweep restarts from 0.
- FIFO pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

Decomposition:
- Package tournament_pkg: ctr2_t (2-bit counter), CTR_WEAK_T=2'b10, branch_meta_t struct {pc, ghr, lhist, pred_global, pred_local, pred_taken}, sat_inc/sat_dec functions.
- One sub-module: branch_meta_fifo (parameterised DEPTH, valid/ready both ends, synchronous clear).

Test Plan:
- Release reset, hold res_valid=0 -> exactly 4096 cycles of all *_wr_en=1 with indices 0..4095 (mod size) and data 2'b10, then init_done=1 and pred_ready=1.
- Enqueue ghr=12'h0A5, lhist=0, global=1, local=0, taken=1; resolve res_taken=0 with glob/cho/loc rd_data=2'b10 -> next cycle mispredict=1, restore_ghr=12'h14A, glob_wr_data=2'b01, cho_wr_data=2'b01, loc_wr_data=2'b01.
- Two back-to-back resolutions to the same ghr, both taken, rd_data=2'b10 both times -> writes 2'b11 then 2'b11 (forwarded, saturated), not 2'b11 then 2'b11 computed from stale data for a decrement case. Repeat with not-taken: 2'b01 then 2'b00.
- Enqueue 8 entries without resolving -> pred_ready=0. One resolution with pred_valid held -> no enqueue that cycle; enqueue accepted the next cycle.
- Enqueue 3, assert flush concurrently with res_valid and pred_valid -> one S1 update, pred dropped, res_ready=0 afterwards.
- Assert reset during RUN with S1 valid -> no write from S1. After release, the INIT sweep restarts at index 0.
